// File: rtl/ball_controller.sv
// rtl/ball_controller.sv - pong ball FSM: serve, wall/paddle bounce, miss scoring.
// Optional BALL_SPEEDUP_EN: after 7 paddle hits each frame moves the ball 2 px.
module ball_controller #(
   parameter logic [9:0] Y_MIN     = 10'd8,
   parameter logic [9:0] Y_MAX     = 10'd472,
   parameter logic [9:0] BALL_R    = 10'd4,
   parameter logic [9:0] PAD_L_X   = 10'd16,
   parameter logic [9:0] PAD_R_X   = 10'd624,
   parameter logic [9:0] PAD_HALF  = 10'd24,
   parameter logic [9:0] MISS_L_X  = 10'd8,
   parameter logic [9:0] MISS_R_X  = 10'd632,
   parameter logic [5:0] SERVE_DLY = 6'd60,
   parameter logic [3:0] WIN_SCORE = 4'd9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [9:0] ball_center_x,
   input  logic [9:0] ball_center_y,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   output logic [3:0] cw_ballMovement,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       point,
   output logic       game_over
);

   typedef enum logic [2:0] {S_IDLE, S_CENTER, S_WAIT, S_PLAY, S_OVER} state_t;

   localparam logic [3:0] CW_HOLD   = 4'b0000;
   localparam logic [3:0] CW_CENTER = 4'b0101;

   state_t     state_q;
   logic [3:0] cw_q;
   logic [3:0] score_l_q, score_r_q;
   logic       point_q, game_over_q;
   logic       dir_x_q, dir_y_q;
   logic [5:0] cnt_q;

   logic        dir_x_d, dir_y_d;
   logic [3:0]  cw_d;
   logic [10:0] x_w, y_w, dy_l, dy_r;
   logic        miss_l, miss_r, top_hit, bot_hit, pad_l_hit, pad_r_hit;
   logic [3:0]  score_l_inc, score_r_inc;

   // All comparisons are done 11 bits wide so y-BALL_R going negative still counts as a wall hit.
   always_comb begin
      x_w  = {1'b0, ball_center_x};
      y_w  = {1'b0, ball_center_y};
      dy_l = (ball_center_y >= paddle_l_y) ? ({1'b0, ball_center_y} - {1'b0, paddle_l_y})
                                           : ({1'b0, paddle_l_y} - {1'b0, ball_center_y});
      dy_r = (ball_center_y >= paddle_r_y) ? ({1'b0, ball_center_y} - {1'b0, paddle_r_y})
                                           : ({1'b0, paddle_r_y} - {1'b0, ball_center_y});
      miss_l    = x_w <= {1'b0, MISS_L_X};
      miss_r    = x_w >= {1'b0, MISS_R_X};
      top_hit   = !dir_y_q && (y_w <= ({1'b0, Y_MIN} + {1'b0, BALL_R}));
      bot_hit   = dir_y_q && ((y_w + {1'b0, BALL_R}) >= {1'b0, Y_MAX});
      pad_l_hit = !dir_x_q && (x_w <= ({1'b0, PAD_L_X} + {1'b0, BALL_R})) && (dy_l <= {1'b0, PAD_HALF});
      pad_r_hit = dir_x_q && ((x_w + {1'b0, BALL_R}) >= {1'b0, PAD_R_X}) && (dy_r <= {1'b0, PAD_HALF});
      dir_x_d   = pad_l_hit ? 1'b1 : (pad_r_hit ? 1'b0 : dir_x_q);
      dir_y_d   = top_hit ? 1'b1 : (bot_hit ? 1'b0 : dir_y_q);
      case ({dir_x_d, dir_y_d})
         2'b11:   cw_d = 4'b0001;
         2'b00:   cw_d = 4'b0010;
         2'b01:   cw_d = 4'b0011;
         default: cw_d = 4'b0100;
      endcase
      score_l_inc = score_l_q + 4'd1;
      score_r_inc = score_r_q + 4'd1;
   end

`ifdef BALL_SPEEDUP_EN
   logic [2:0] hits_q;
   logic       extra_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cw_q        <= CW_HOLD;
         score_l_q   <= 4'd0;
         score_r_q   <= 4'd0;
         point_q     <= 1'b0;
         game_over_q <= 1'b0;
         dir_x_q     <= 1'b1;
         dir_y_q     <= 1'b1;
         cnt_q       <= 6'd0;
`ifdef BALL_SPEEDUP_EN
         hits_q      <= 3'd0;
         extra_q     <= 1'b0;
`endif
      end else begin
         cw_q    <= CW_HOLD;
         point_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
         extra_q <= 1'b0;
         if (extra_q) cw_q <= cw_q;
`endif
         case (state_q)
            S_IDLE: begin
               if (start) state_q <= S_CENTER;
            end
            S_CENTER: begin
               cw_q    <= CW_CENTER;
               cnt_q   <= SERVE_DLY;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == 6'd0) begin
                  state_q <= S_PLAY;
               end else if (frame_tick) begin
                  cnt_q <= cnt_q - 6'd1;
                  if (cnt_q == 6'd1) state_q <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (frame_tick) begin
                  if (miss_l || miss_r) begin
                     // The ball is served back toward whoever conceded.
                     point_q <= 1'b1;
                     dir_x_q <= miss_r;
                     dir_y_q <= !dir_y_q;
                     cw_q    <= CW_HOLD;
`ifdef BALL_SPEEDUP_EN
                     hits_q  <= 3'd0;
                     extra_q <= 1'b0;
`endif
                     if (miss_r) begin
                        score_l_q <= score_l_inc;
                        state_q   <= (score_l_inc == WIN_SCORE) ? S_OVER : S_CENTER;
                        game_over_q <= (score_l_inc == WIN_SCORE);
                     end else begin
                        score_r_q <= score_r_inc;
                        state_q   <= (score_r_inc == WIN_SCORE) ? S_OVER : S_CENTER;
                        game_over_q <= (score_r_inc == WIN_SCORE);
                     end
                  end else begin
                     dir_x_q <= dir_x_d;
                     dir_y_q <= dir_y_d;
                     cw_q    <= cw_d;
`ifdef BALL_SPEEDUP_EN
                     if ((pad_l_hit || pad_r_hit) && (hits_q != 3'd7)) hits_q <= hits_q + 3'd1;
                     extra_q <= (hits_q == 3'd7);
`endif
                  end
               end
            end
            S_OVER: begin
               if (start) begin
                  score_l_q   <= 4'd0;
                  score_r_q   <= 4'd0;
                  game_over_q <= 1'b0;
                  state_q     <= S_CENTER;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cw_ballMovement = cw_q;
   assign score_l         = score_l_q;
   assign score_r         = score_r_q;
   assign point           = point_q;
   assign game_over       = game_over_q;

endmodule

// File: tb/tb_ball_controller.sv
// tb/tb_ball_controller.sv - directed scoreboard bench for ball_controller.
module tb_ball_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic [9:0] ball_center_x = 10'd320;
   logic [9:0] ball_center_y = 10'd220;
   logic [9:0] paddle_l_y = 10'd240;
   logic [9:0] paddle_r_y = 10'd240;
   logic [3:0] cw_ballMovement, score_l, score_r;
   logic       point, game_over;

   int tests = 0;
   int fails = 0;
   logic [3:0] exp_q[$];

   ball_controller dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
      .ball_center_x(ball_center_x), .ball_center_y(ball_center_y),
      .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
      .cw_ballMovement(cw_ballMovement), .score_l(score_l), .score_r(score_r),
      .point(point), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_pos(input logic [9:0] x, input logic [9:0] y,
                          input logic [9:0] pl, input logic [9:0] pr);
      ball_center_x = x;
      ball_center_y = y;
      paddle_l_y    = pl;
      paddle_r_y    = pr;
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   // One play tick: the expected code is queued at drive time and popped when the DUT emits.
   task automatic tick_expect(input string tag, input logic [9:0] x, input logic [9:0] y,
                              input logic [9:0] pl, input logic [9:0] pr, input logic [3:0] code);
      logic [3:0] e;
      set_pos(x, y, pl, pr);
      exp_q.push_back(code);
      pulse_tick();
      e = exp_q.pop_front();
      check(tag, {6'd0, cw_ballMovement}, {6'd0, e});
      step();
      check({tag, "_after"}, {6'd0, cw_ballMovement}, 10'd0);
   endtask

   task automatic serve();
      logic quiet;
      quiet = 1'b1;
      for (int i = 0; i < 60; i++) begin
         pulse_tick();
         if (cw_ballMovement !== 4'd0) quiet = 1'b0;
         step();
         if (cw_ballMovement !== 4'd0) quiet = 1'b0;
      end
      check("serve_quiet", {9'd0, quiet}, 10'd1);
   endtask

   task automatic do_miss(input string tag, input logic [9:0] x, input logic [3:0] exp_l,
                          input logic [3:0] exp_r, input logic exp_over);
      set_pos(x, 10'd200, 10'd200, 10'd200);
      pulse_tick();
      check({tag, "_nocode"}, {6'd0, cw_ballMovement}, 10'd0);
      check({tag, "_point"}, {9'd0, point}, 10'd1);
      check({tag, "_score_l"}, {6'd0, score_l}, {6'd0, exp_l});
      check({tag, "_score_r"}, {6'd0, score_r}, {6'd0, exp_r});
      check({tag, "_over"}, {9'd0, game_over}, {9'd0, exp_over});
      step();
      check({tag, "_point_off"}, {9'd0, point}, 10'd0);
      if (exp_over) begin
         check({tag, "_hold"}, {6'd0, cw_ballMovement}, 10'd0);
      end else begin
         check({tag, "_recentre"}, {6'd0, cw_ballMovement}, 10'd5);
         serve();
      end
   endtask

   initial begin
      step();
      check("rst_cw", {6'd0, cw_ballMovement}, 10'd0);
      check("rst_score_l", {6'd0, score_l}, 10'd0);
      check("rst_score_r", {6'd0, score_r}, 10'd0);
      check("rst_point", {9'd0, point}, 10'd0);
      check("rst_over", {9'd0, game_over}, 10'd0);
      reset = 1'b0;
      step();

      start = 1'b1;
      step();
      start = 1'b0;
      check("idle_hold", {6'd0, cw_ballMovement}, 10'd0);
      step();
      check("center_code", {6'd0, cw_ballMovement}, 10'd5);
      step();
      check("center_once", {6'd0, cw_ballMovement}, 10'd0);
      serve();
      tick_expect("first_move", 10'd320, 10'd220, 10'd240, 10'd240, 4'b0001);

      tick_expect("bottom_wall", 10'd300, 10'd470, 10'd240, 10'd240, 4'b0100);
      tick_expect("top_wall", 10'd300, 10'd12, 10'd240, 10'd240, 4'b0001);
      tick_expect("right_pad", 10'd620, 10'd200, 10'd240, 10'd200, 4'b0011);
      tick_expect("left_pad", 10'd20, 10'd200, 10'd210, 10'd240, 4'b0001);
      tick_expect("right_pad2", 10'd620, 10'd200, 10'd240, 10'd200, 4'b0011);
      tick_expect("left_pad_far", 10'd20, 10'd200, 10'd260, 10'd240, 4'b0011);
      tick_expect("left_pad_edge", 10'd20, 10'd200, 10'd176, 10'd240, 4'b0001);
      tick_expect("corner", 10'd620, 10'd470, 10'd240, 10'd470, 4'b0010);
      tick_expect("top_underflow", 10'd300, 10'd2, 10'd240, 10'd240, 4'b0011);

      do_miss("miss_r", 10'd632, 4'd1, 4'd0, 1'b0);
      tick_expect("serve_dir_r", 10'd320, 10'd220, 10'd240, 10'd240, 4'b0100);

      for (int i = 0; i < 9; i++) begin
         do_miss("miss_l", 10'd8, 4'd1, 4'(i + 1), (i == 8));
         if (i == 0) tick_expect("serve_dir_l", 10'd320, 10'd220, 10'd240, 10'd240, 4'b0011);
      end
      set_pos(10'd320, 10'd220, 10'd240, 10'd240);
      pulse_tick();
      check("over_hold", {6'd0, cw_ballMovement}, 10'd0);
      check("over_flag", {9'd0, game_over}, 10'd1);

      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_score_l", {6'd0, score_l}, 10'd0);
      check("restart_score_r", {6'd0, score_r}, 10'd0);
      check("restart_over", {9'd0, game_over}, 10'd0);
      step();
      check("restart_center", {6'd0, cw_ballMovement}, 10'd5);
      serve();

      for (int h = 0; h < 7; h++) begin
         if (h % 2 == 0) tick_expect("hit_l", 10'd20, 10'd200, 10'd200, 10'd240, 4'b0001);
         else            tick_expect("hit_r", 10'd620, 10'd200, 10'd240, 10'd200, 4'b0011);
      end
      set_pos(10'd320, 10'd220, 10'd240, 10'd240);
      pulse_tick();
      check("fast_c1", {6'd0, cw_ballMovement}, 10'd1);
      step();
`ifdef BALL_SPEEDUP_EN
      check("fast_c2", {6'd0, cw_ballMovement}, 10'd1);
      step();
`endif
      check("fast_end", {6'd0, cw_ballMovement}, 10'd0);

      do_miss("miss_fast", 10'd632, 4'd1, 4'd0, 1'b0);
      tick_expect("slow_again", 10'd320, 10'd220, 10'd240, 10'd240, 4'b0100);

      pulse_tick();
      check("pre_reset_code", {6'd0, cw_ballMovement}, 10'd4);
      reset = 1'b1;
      #1;
      check("abort_cw", {6'd0, cw_ballMovement}, 10'd0);
      check("abort_score_l", {6'd0, score_l}, 10'd0);
      check("abort_point", {9'd0, point}, 10'd0);
      step();
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ball_controller.md
BALL_CONTROLLER -- requirements
Module: ball_controller

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- Y_MIN 10'd8: top wall, pixels.
- Y_MAX 10'd472: bottom wall, pixels.
- BALL_R 10'd4: ball radius.
- PAD_L_X 10'd16: left paddle face, x.
- PAD_R_X 10'd624: right paddle face, x.
- PAD_HALF 10'd24: paddle half-height.
- MISS_L_X 10'd8: left miss line.
- MISS_R_X 10'd632: right miss line.
- SERVE_DLY 6'd60: frame_ticks between re-centre and play.
- WIN_SCORE 4'd9: points needed to win.
REQ-002 Ports (name, direction, width, meaning), one per line; one clock; reset is asynchronous and active-high:
- clk  in  1: system clock.
- reset  in  1: asynchronous, active-high reset.
- frame_tick  in  1: one-cycle pulse per video frame.
- start  in  1: level; begins or restarts the game.
- ball_center_x  in  10: current ball x.
- ball_center_y  in  10: current ball y.
- paddle_l_y  in  10: left paddle centre y.
- paddle_r_y  in  10: right paddle centre y.
- cw_ballMovement  out  4: ball movement control word.
- score_l  out  4: left player score.
- score_r  out  4: right player score.
- point  out  1: one-cycle pulse on each score.
- game_over  out  1: high while in state OVER.

Function
REQ-003 cw_ballMovement codes SHALL be: 0000 hold, 0001 down-right, 0010 up-left, 0011 down-left, 0100 up-right, 0101 re-centre; it SHALL be 0000 in every cycle not explicitly specified below.
REQ-004 The FSM SHALL have states IDLE, CENTER, WAIT, PLAY and OVER.
REQ-005 IDLE: when start=1, go to CENTER; outputs hold.
REQ-006 CENTER: emit 0101 for exactly one cycle, load the serve counter with SERVE_DLY, go to WAIT.
REQ-007 WAIT: decrement the counter on each frame_tick; when the counter reaches 0, go to PLAY.
REQ-008 Direction registers SHALL be dir_x (1=right) and dir_y (1=down).
REQ-009 PLAY: on each frame_tick, evaluate the rules below against the sampled inputs, update dir_x/dir_y, and in the next cycle emit a single movement code built from the updated directions (1-cycle latency).
REQ-010 Wall rule: when dir_y=0 and y-BALL_R<=Y_MIN, set dir_y=1; when dir_y=1 and y+BALL_R>=Y_MAX, set dir_y=0.
REQ-011 Left paddle: when dir_x=0, x-BALL_R<=PAD_L_X, and |y-paddle_l_y|<=PAD_HALF, set dir_x=1; the right paddle rule mirrors this using x+BALL_R>=PAD_R_X.
REQ-012 The wall rule and a paddle rule SHALL both apply on the same tick (corner bounce).
REQ-013 Miss rule: x<=MISS_L_X scores a point for the right player, x>=MISS_R_X scores for the left player; a miss has priority over a paddle bounce on the same tick, and no movement code is emitted on that tick.
REQ-014 On a score: increment the scorer's score, pulse point for one cycle, set dir_x toward the player who conceded, toggle dir_y, then go to OVER if the new score equals WIN_SCORE, otherwise to CENTER.
REQ-015 OVER: hold code 0000, game_over=1; when start=1, clear both scores and go to CENTER.
REQ-016 Absolute differences SHALL be computed 11-bit unsigned with no wrap; y-BALL_R<0 SHALL count as <=Y_MIN.
REQ-017 frame_tick arriving while a movement code is being emitted SHALL be evaluated normally; codes SHALL never be emitted outside PLAY.

Reset
REQ-018 On reset: state=IDLE, cw_ballMovement=0000, scores=0, point=0, game_over=0, dir_x=1, dir_y=1, counters=0; reset asserted mid-game SHALL abort within the same cycle.

Configuration
REQ-019 Macro BALL_SPEEDUP_EN, when defined: a 3-bit hit counter increments on each paddle bounce and saturates at 7; once saturated, each PLAY frame_tick emits the movement code for 2 consecutive cycles (2 px/frame); the counter clears on each point and on reset.
REQ-020 Without BALL_SPEEDUP_EN: no hit counter exists, and movement is always 1 cycle per frame_tick.

Verification
REQ-021 reset, then start=1: one cycle of 0101, then after 60 frame_ticks the first tick with x=320,y=220 yields a single 0001 one cycle later.
REQ-022 dir up-right, y=12, x=300, tick: dir_y flips, emit 0001.
REQ-023 dir left, x=20, y=200, paddle_l_y=210, tick: emit 0100 or 0001 matching dir_y; with paddle_l_y=260, no bounce.
REQ-024 x=632 on tick: score_l+1, point pulse, next code 0101, no movement code on that tick.
REQ-025 score_r=8 and a left miss: score_r=9, game_over=1, code held at 0000; start: scores cleared, code 0101.
REQ-026 BALL_SPEEDUP_EN defined, 7 paddle hits: each later tick yields 2 consecutive movement cycles; after a point, 1 cycle.
